// File: rtl/aff_resultat_de.sv
//==============================================================================
// aff_resultat_de : binary die result -> "<type><N digits>" 7-seg display,
// sequential double-dabble with leading-zero blanking. Rev 1.0
// Optional blink after each update: define AFF_CLIGNOTE_EN.
//==============================================================================
`default_nettype none

module aff_resultat_de #(
  parameter int         WIDTH     = 10,
  parameter int         NDIG      = 3,
  parameter logic [3:0] TYPE_CODE = 4'hD,
  parameter int         BLINK_DIV = 12500000,
  parameter int         BLINK_N   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  input  logic              en_type,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [6:0]        hex_t,
  output logic [7*NDIG-1:0] hex
);

  localparam int          c_BW    = 4 * NDIG;
  localparam int          c_CW    = $clog2(WIDTH + 1);
  localparam logic [31:0] c_LIMIT = 32'(10 ** NDIG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_BLINK = 2'd2
  } t_state;

  t_state           r_state;
  logic [WIDTH-1:0] r_val;
  logic [c_BW-1:0]  r_acc;
  logic [c_BW-1:0]  r_dig;
  logic [c_CW-1:0]  r_cnt;
  logic             r_ovf_cap;
  logic [c_BW-1:0]  w_adj;
  logic [c_BW-1:0]  w_step;
  logic             w_off;
  logic             w_any;

  // Active-low segments, bit 0 = a ... bit 6 = g; disabled digit is all-off.
  function automatic logic [6:0] f_seg7(input logic [3:0] code, input logic en);
    logic [6:0] s;
    s = 7'h7F;
    case (code)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
    endcase
    return en ? s : 7'h7F;
  endfunction

  // One shift-and-add-3 step; the bit leaving the top of the accumulator is dropped.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < NDIG; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
    w_step = c_BW'({w_adj, r_val[WIDTH-1]});
  end

`ifdef AFF_CLIGNOTE_EN
  localparam int c_DW = $clog2(BLINK_DIV + 1);
  localparam int c_HW = $clog2(2 * BLINK_N + 1);
  logic [c_DW-1:0] r_div;
  logic [c_HW-1:0] r_half;
  logic            r_phase;
  assign w_off = r_phase;
`else
  logic w_unused_blink;
  assign w_unused_blink = (BLINK_DIV > 0) ^ (BLINK_N > 0);
  assign w_off = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_val     <= '0;
      r_acc     <= '0;
      r_dig     <= '0;
      r_cnt     <= '0;
      r_ovf_cap <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
`ifdef AFF_CLIGNOTE_EN
      r_div     <= '0;
      r_half    <= '0;
      r_phase   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_CONV: begin
          r_acc <= w_step;
          r_val <= r_val << 1;
          r_cnt <= r_cnt - c_CW'(1);
          if (r_cnt == c_CW'(1)) begin
            r_dig <= r_ovf_cap ? {NDIG{4'h9}} : w_step;
            ovf   <= r_ovf_cap;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef AFF_CLIGNOTE_EN
            r_state <= S_BLINK;
            r_div   <= '0;
            r_half  <= '0;
            r_phase <= 1'b1;
`else
            r_state <= S_IDLE;
`endif
          end
        end
        default: begin
`ifdef AFF_CLIGNOTE_EN
          if (r_state == S_BLINK) begin
            if (r_div == c_DW'(BLINK_DIV - 1)) begin
              r_div   <= '0;
              r_phase <= ~r_phase;
              r_half  <= r_half + c_HW'(1);
              if (r_half == c_HW'(2 * BLINK_N - 1)) begin
                r_state <= S_IDLE;
                r_phase <= 1'b0;
              end
            end else begin
              r_div <= r_div + c_DW'(1);
            end
          end
`endif
          // A load here (idle or blinking) overrides any blink bookkeeping above.
          if (load) begin
            r_val     <= value;
            r_acc     <= '0;
            r_cnt     <= c_CW'(WIDTH);
            r_ovf_cap <= (32'(value) >= c_LIMIT);
            busy      <= 1'b1;
            r_state   <= S_CONV;
`ifdef AFF_CLIGNOTE_EN
            r_phase   <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  // Digit i lights when it or any higher digit is nonzero; units always lit.
  always_comb begin
    w_any = 1'b0;
    hex   = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      w_any = w_any | (r_dig[4*i +: 4] != 4'd0) | (i == 0);
      hex[7*i +: 7] = f_seg7(r_dig[4*i +: 4], w_any & ~w_off);
    end
  end

  assign hex_t = f_seg7(TYPE_CODE, en_type);

endmodule

`default_nettype wire

// File: tb/tb_aff_resultat_de.sv
//==============================================================================
// tb_aff_resultat_de : scoreboard bench for aff_resultat_de (default params).
//==============================================================================
`default_nettype none

module tb_aff_resultat_de;

  localparam int BD = 4;
  localparam int BN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  value;
  logic        load;
  logic        en_type;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [6:0]  hex_t;
  logic [20:0] hex;

  typedef struct packed {
    logic [11:0] d;
    logic [2:0]  lit;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   fails  = 0;
  int   n_done = 0;

  aff_resultat_de #(
    .WIDTH(10), .NDIG(3), .TYPE_CODE(4'hD), .BLINK_DIV(BD), .BLINK_N(BN)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .en_type(en_type),
    .busy(busy), .done(done), .ovf(ovf), .hex_t(hex_t), .hex(hex)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [20:0] exp_hex(input logic [11:0] d, input logic [2:0] lit);
    logic [20:0] h;
    h = '1;
    for (int i = 0; i < 3; i++) h[7*i +: 7] = lit[i] ? seg(d[4*i +: 4]) : 7'h7F;
    return h;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_ovf", 32'(ovf), 32'(e.o));
`ifdef AFF_CLIGNOTE_EN
          repeat (BD) @(negedge clk);
`endif
          chk("sb_hex", 32'(hex), 32'(exp_hex(e.d, e.lit)));
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic run(input logic [9:0] v, input logic [11:0] d, input logic [2:0] lit,
                     input logic o);
    int nb, d0;
    sb.push_back('{d: d, lit: lit, o: o});
    d0 = n_done;
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(nb), 32'd10);
    repeat (20) @(negedge clk);
    chk("done_pulses", 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    int d0, n;
    rst = 1'b1; load = 1'b0; value = '0; en_type = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_hex", 32'(hex), 32'(exp_hex(12'h000, 3'b001)));
    chk("rst_hex_t", 32'(hex_t), 32'h21);
    rst = 1'b0;
    en_type = 1'b0;
    @(negedge clk);
    chk("hex_t_blank", 32'(hex_t), 32'h7F);
    en_type = 1'b1;

    run(10'd7,    12'h007, 3'b001, 1'b0);
    run(10'd100,  12'h100, 3'b111, 1'b0);
    run(10'd999,  12'h999, 3'b111, 1'b0);
    run(10'd1000, 12'h999, 3'b111, 1'b1);

    // Second load while busy must be ignored.
    sb.push_back('{d: 12'h042, lit: 3'b011, o: 1'b0});
    d0 = n_done;
    value = 10'd42; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    value = 10'd5; load = 1'b1;
    @(negedge clk);
    load = 1'b0; value = '0;
    wait_idle();
    repeat (20) @(negedge clk);
    chk("ignored_load_dones", 32'(n_done - d0), 32'd1);

    // Reset in the middle of a conversion discards it.
    run(10'd12, 12'h012, 3'b011, 1'b0);
    d0 = n_done;
    value = 10'd250; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_hex", 32'(hex), 32'(exp_hex(12'h000, 3'b001)));
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(n_done - d0), 32'd0);

`ifdef AFF_CLIGNOTE_EN
    sb.push_back('{d: 12'h066, lit: 3'b011, o: 1'b0});
    value = 10'd66; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("blink_done_seen", 32'(done), 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk("blink_phase", 32'(hex),
          (i < 16 && ((i / 4) % 2) == 0) ? 32'h1FFFFF : 32'(exp_hex(12'h066, 3'b011)));
      @(negedge clk);
    end

    sb.push_back('{d: 12'h066, lit: 3'b011, o: 1'b0});
    value = 10'd66; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    sb.push_back('{d: 12'h003, lit: 3'b001, o: 1'b0});
    value = 10'd3; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("blink_abort_busy", 32'(busy), 32'd1);
    chk("blink_abort_lit", 32'(hex), 32'(exp_hex(12'h066, 3'b011)));
    wait_idle();
    repeat (24) @(negedge clk);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/aff_resultat_de.md
Name: aff_resultat_de

Overview:
- Successor to the fixed 3-digit dice display: shows a die result as "<type digit><N decimal digits>" on 7-segment displays.
- Takes a binary result, not BCD. Converts it sequentially (shift-and-add-3, one bit per clock) and blanks leading zeros.
- Handshakes with the dice roller through load/busy/done.
- Sits between the roll FSM and the board HEX outputs; one Aff7Seg decoder per digit.

Parameters:
- WIDTH, 10, bit width of the binary result input (1..20).
- NDIG, 3, number of decimal result digits (1..6).
- TYPE_CODE, 4'hD, code shown on the type digit ("d").
- BLINK_DIV, 12500000, clock cycles per blink half-period (used only with AFF_CLIGNOTE_EN).
- BLINK_N, 3, number of full blink periods after an update (used only with AFF_CLIGNOTE_EN).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- value, input, WIDTH, binary result to display; sampled on load.
- load, input, 1, start-conversion strobe.
- en_type, input, 1, 1 lights the type digit; 0 blanks it.
- busy, output, 1, conversion in progress.
- done, output, 1, one-cycle pulse when displayed digits update.
- ovf, output, 1, last loaded value ≥ 10^NDIG.
- hex_t, output, 7, type digit segments.
- hex, output, 7*NDIG, result digit segments; digit i (units = 0) occupies bits [7i+6:7i].

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, ovf=0, stored digits all 0, blink inactive. Display then shows type digit (if en_type) plus a single "0" in units, other digits blank.
- Reset mid-conversion or mid-blink aborts it. Partial results are discarded.
- States: IDLE, CONV, plus BLINK when the macro is defined.
- Load in IDLE (or in BLINK): when load=1 at edge k:
  - capture value;
  - clear BCD accumulator;
  - bit counter = WIDTH;
  - busy=1 from edge k;
  - go to CONV.
- Load while busy is ignored; the captured value is not changed.
- CONV:
  - Each edge: add 3 to every BCD nibble ≥5, then shift left 1 bit, taking the MSB of the captured value.
  - BCD accumulator is 4*NDIG bits; bits shifted out above it are dropped.
- End of conversion, at edge k+WIDTH (after the WIDTH-th step):
  - stored digits ← accumulator;
  - busy=0;
  - done=1 for exactly the following cycle;
  - go to IDLE (or BLINK).
- Display keeps showing the previous value until this edge. Latency from load to new digits = WIDTH clocks.
- Overflow: ovf is computed at load as (value ≥ 10^NDIG) and registered with the other outputs at completion. If ovf=1, stored digits are all 9 (saturation), not the truncated conversion.
- Leading-zero blanking: digit 0 is always lit. Digit i≥1 is lit iff some stored digit j≥i is nonzero. Blanked digit = all segments off.
- Segment encoding and polarity: identical to Aff7Seg. hex_t = Aff7Seg(TYPE_CODE, en_type). Both are combinational from registered state.
- load asserted during the done cycle starts a new conversion normally.

Optional Feature:
- Macro: AFF_CLIGNOTE_EN.
- Defined:
  - After each completion (done pulse), enter BLINK.
  - A BLINK_DIV counter toggles a phase bit. During the "off" phase all result digits are blanked; hex_t is unaffected.
  - Ends after 2*BLINK_N half-periods, with digits lit → IDLE.
  - load in BLINK aborts the blink and starts CONV.
  - busy=0 during BLINK.
- Not defined: no BLINK state or counter is synthesised; BLINK_DIV and BLINK_N are unused. Digits are lit steadily after completion.

Test Plan:
- Reset: assert rst 2 cycles → busy=0, done=0, ovf=0, units shows "0", digits 1..NDIG-1 blank, hex_t shows "d" when en_type=1.
- Defaults, value=7, load 1 cycle → busy high exactly 10 cycles, done single pulse, digits 0,0,7 with only units lit.
- value=100 → digits "100" all lit. value=999 → "999", ovf=0. value=1000 → "999", ovf=1.
- load=1 with value=42, then load pulsed with value=5 three cycles later → second load ignored, display "42", one done pulse only.
- rst asserted at step 5 of a conversion of 250 after previous display 12 → display returns to "0", busy=0, no done.
- With AFF_CLIGNOTE_EN, BLINK_DIV=4, BLINK_N=2, value=66:
  - result digits blank/lit alternately every 4 cycles for 16 cycles, then steady "66";
  - load mid-blink → busy next cycle, blink stops.
